sap1_datapath: RTL

Datapath that answers the SAP-1 stage controller's control word. It holds the program counter, memory address register, 16x8 RAM, instruction register, accumulator A, operand register B, adder/subtractor and output register, all on one shared 8-bit bus. It returns the opcode to the controller and exposes the output register and status flags. A side port loads the program into RAM before a run.

---
 rtl/sap1_datapath_if.sv | 39 +++
 rtl/sap1_datapath.sv | 110 +++++++++++
 2 files changed

// File: rtl/sap1_datapath_if.sv
// Control and status bundle between the SAP-1 stage controller and its datapath.
// The master side drives the control word and program port; the slave side reports status.
interface sap1_datapath_if;
    logic       pc_en_i;
    logic       pc_inc_i;
    logic       mem_load_i;
    logic       mem_en_i;
    logic       ins_load_i;
    logic       ins_en_i;
    logic       a_load_i;
    logic       a_en_i;
    logic       adder_sub_i;
    logic       adder_en_i;
    logic       b_load_i;
    logic       output_load_i;
    logic       prog_we_i;
    logic [3:0] prog_addr_i;
    logic [7:0] prog_data_i;
    logic [3:0] opcode_o;
    logic [7:0] out_o;
    logic       carry_o;
    logic       zero_o;
    logic [7:0] bus_o;
    logic       bus_conflict_o;

    modport master (
        output pc_en_i, pc_inc_i, mem_load_i, mem_en_i, ins_load_i, ins_en_i,
               a_load_i, a_en_i, adder_sub_i, adder_en_i, b_load_i, output_load_i,
               prog_we_i, prog_addr_i, prog_data_i,
        input  opcode_o, out_o, carry_o, zero_o, bus_o, bus_conflict_o
    );

    modport slave (
        input  pc_en_i, pc_inc_i, mem_load_i, mem_en_i, ins_load_i, ins_en_i,
               a_load_i, a_en_i, adder_sub_i, adder_en_i, b_load_i, output_load_i,
               prog_we_i, prog_addr_i, prog_data_i,
        output opcode_o, out_o, carry_o, zero_o, bus_o, bus_conflict_o
    );
endinterface

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A, B, adder/subtractor and OUT on one 8-bit bus.
// Sequencing is owned entirely by the external stage controller.
module sap1_datapath (
    input  logic            clk_i,
    input  logic            reset_ni,
    sap1_datapath_if.slave  dp
);

    logic [3:0] pc_q, pc_d;
    logic [3:0] mar_q, mar_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] out_q, out_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;
    logic       conflict_q, conflict_d;
    logic [7:0] ram_q [16];

    logic [7:0] ram_rd;
    logic [7:0] bus;
    logic [8:0] alu_sum;
    logic [2:0] drv_cnt;

    // Subtraction is A + ~B + 1, so bit 8 reads as "no borrow" (A >= B).
    function automatic logic [8:0] alu(input logic [7:0] lhs, input logic [7:0] rhs,
                                       input logic sub);
        logic [8:0] r;
        if (sub) r = {1'b0, lhs} + {1'b0, ~rhs} + 9'd1;
        else     r = {1'b0, lhs} + {1'b0, rhs};
        return r;
    endfunction

    assign ram_rd  = ram_q[mar_q];
    assign alu_sum = alu(a_q, b_q, dp.adder_sub_i);

    assign drv_cnt = {2'b00, dp.pc_en_i} + {2'b00, dp.mem_en_i} + {2'b00, dp.ins_en_i}
                   + {2'b00, dp.a_en_i} + {2'b00, dp.adder_en_i};

    always_comb begin
        bus = 8'h00;
        if (dp.pc_en_i)         bus = {4'h0, pc_q};
        else if (dp.mem_en_i)   bus = ram_rd;
        else if (dp.ins_en_i)   bus = {4'h0, ir_q[3:0]};
        else if (dp.a_en_i)     bus = a_q;
        else if (dp.adder_en_i) bus = alu_sum[7:0];
    end

    always_comb begin
        pc_d       = pc_q;
        mar_d      = mar_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        out_d      = out_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        conflict_d = conflict_q | (drv_cnt > 3'd1);

        if (dp.pc_inc_i)      pc_d  = pc_q + 4'd1;
        if (dp.mem_load_i)    mar_d = bus[3:0];
        if (dp.ins_load_i)    ir_d  = bus;
        if (dp.a_load_i)      a_d   = bus;
        if (dp.b_load_i)      b_d   = bus;
        if (dp.output_load_i) out_d = bus;

        // Flags track only results that actually land in A through the adder.
        if (dp.a_load_i && dp.adder_en_i) begin
            carry_d = alu_sum[8];
            zero_d  = (alu_sum[7:0] == 8'h00);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            pc_q       <= 4'h0;
            mar_q      <= 4'h0;
            ir_q       <= 8'h00;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            out_q      <= 8'h00;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            mar_q      <= mar_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            out_q      <= out_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            conflict_q <= conflict_d;
        end
    end

    // Program port is independent of reset so a program can be loaded while held in reset.
    always_ff @(posedge clk_i) begin
        if (dp.prog_we_i) ram_q[dp.prog_addr_i] <= dp.prog_data_i;
    end

    assign dp.opcode_o       = ir_q[7:4];
    assign dp.out_o          = out_q;
    assign dp.carry_o        = carry_q;
    assign dp.zero_o         = zero_q;
    assign dp.bus_o          = bus;
    assign dp.bus_conflict_o = conflict_q;

endmodule
